// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg
//   Shared types, default 640x480@60 timing and pixel helpers for the
//   VGA FIFO scan-out block.
//   Optional feature macro used by the top level: VGA_TESTPATTERN_EN.
package vga_scanout_pkg;

    typedef enum logic [1:0] {
        S_LOCK = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // 640x480@60 with a 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PREFILL  = 256;

    // Keep the top four bits of each RGB565 channel.
    function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Horizontal/vertical raster counters and raw (undelayed) timing flags.
//   Ports:
//     clk_i        pixel clock
//     clr_i        synchronous clear, holds both counters at 0
//     h_cnt_o      pixel counter, 0..H_TOTAL-1
//     v_cnt_o      line counter, 0..V_TOTAL-1
//     hs_raw_o     horizontal sync, active-low
//     vs_raw_o     vertical sync, active-low
//     active_o     inside the visible area
//     last_cycle_o last pixel of the last line of the frame
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          clr_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          hs_raw_o,
    output logic          vs_raw_o,
    output logic          active_o,
    output logic          last_cycle_o
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign hs_raw_o     = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    assign vs_raw_o     = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
    assign active_o     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign last_cycle_o = h_wrap && (v_cnt_q == V_LAST);

endmodule

// File: rtl/vga_fifo_scanout.sv
// vga_fifo_scanout
//   Read side of the RGB565 pixel FIFO: VGA timing, one pop per active
//   pixel, 4-bit-per-channel RGB output with active-low syncs.
//   Scan-out waits for PLL lock and a FIFO prefill level; a starved
//   active pixel sets a sticky underflow flag.
//   Optional: define VGA_TESTPATTERN_EN to show 8 vertical colour bars
//   while waiting for prefill (S_FILL).
//   Ports:
//     clk_clk              pixel clock (only clock)
//     reset_reset          synchronous active-high reset
//     pll_locked           PLL lock status
//     fifo_rd_en           pop request (q valid one cycle later)
//     fifo_q               popped RGB565 pixel
//     fifo_empty           FIFO empty
//     fifo_used            FIFO fill level
//     vga_r/vga_g/vga_b    colour, 4 bits each
//     vga_hs/vga_vs        syncs, active-low
//     frame_start          one-cycle pulse when pixel (0,0) is at the pins
//     underflow            sticky starvation flag
module vga_fifo_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PREFILL  = DEF_PREFILL
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        pll_locked,
    output logic        fifo_rd_en,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    input  logic [8:0]  fifo_used,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start,
    output logic        underflow
);

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [8:0] PREFILL_L = 9'(PREFILL);

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hs_raw, vs_raw, active, last_cycle;
    logic          cnt_clr, pipe_clr, live, rd_en;

    // Stage 1: aligned with fifo_q becoming valid
    logic          act1_q, hs1_q, vs1_q, fs1_q, pop1_q;
    // Stage 2: output registers driving the pins
    logic [11:0]   rgb_q, rgb_d, pix;
    logic          hs_q, vs_q, fs_q, underflow_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= S_LOCK;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOCK:  if (pll_locked) state_d = S_FILL;
            S_FILL:  if (last_cycle && (fifo_used >= PREFILL_L)) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LOCK;
        endcase
        if (!pll_locked) state_d = S_LOCK;
    end

    // Counters are held in S_LOCK and cleared on the edge that loses lock.
    assign cnt_clr  = reset_reset || !pll_locked || (state_q == S_LOCK);
    assign pipe_clr = reset_reset || !pll_locked;
    assign live     = (state_q != S_LOCK);

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i        (clk_clk),
        .clr_i        (cnt_clr),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .hs_raw_o     (hs_raw),
        .vs_raw_o     (vs_raw),
        .active_o     (active),
        .last_cycle_o (last_cycle)
    );

    assign rd_en      = (state_q == S_RUN) && active && !fifo_empty;
    assign fifo_rd_en = rd_en;

`ifdef VGA_TESTPATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0]  bar;
    logic [11:0] pat1_q, pat_d;

    assign bar   = 3'(h_cnt / BAR_W);
    assign pat_d = ((state_q == S_FILL) && active)
                   ? {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}} : '0;

    always_ff @(posedge clk_clk) begin
        if (pipe_clr) pat1_q <= '0;
        else          pat1_q <= pat_d;
    end

    assign pix = pop1_q ? rgb565_to_rgb444(fifo_q) : pat1_q;
`else
    assign pix = pop1_q ? rgb565_to_rgb444(fifo_q) : '0;
`endif

    // Starved pixels arrive here with pop1_q=0 and stay black.
    assign rgb_d = act1_q ? pix : '0;

    always_ff @(posedge clk_clk) begin
        if (pipe_clr) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
            pop1_q <= 1'b0;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            // Counters sit at (0,0) in S_LOCK; mask so nothing leaks out.
            act1_q <= live && active;
            hs1_q  <= !live || hs_raw;
            vs1_q  <= !live || vs_raw;
            fs1_q  <= live && (h_cnt == '0) && (v_cnt == '0);
            pop1_q <= rd_en;
            rgb_q  <= rgb_d;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
            fs_q   <= fs1_q;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            underflow_q <= 1'b0;
        else if ((state_q == S_RUN) && active && fifo_empty)
            underflow_q <= 1'b1;
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = fs_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fifo_scanout.sv
// tb_vga_fifo_scanout
//   Directed bench for vga_fifo_scanout with reduced timing
//   (H 8/2/2/2 -> 14 pixels, V 4/1/1/1 -> 7 lines, 98-cycle frame,
//   PREFILL 4). Honours VGA_TESTPATTERN_EN for the fill-pattern pixel.
module tb_vga_fifo_scanout;

    localparam int HT    = 14;
    localparam int FRAME = 98;

    logic        clk = 1'b0;
    logic        reset_reset, pll_locked, fifo_rd_en, fifo_empty;
    logic [15:0] fifo_q = '0;
    logic [8:0]  fifo_used;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start, underflow;
    logic [11:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;
    int fc       = 0;
    int pop_total = 0;

    always #5 clk = ~clk;
    assign rgb = {vga_r, vga_g, vga_b};

    vga_fifo_scanout #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .PREFILL  (4)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .pll_locked  (pll_locked),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .fifo_used   (fifo_used),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    // Normal-mode FIFO: q updates on the edge that sees rd_en.
    // Word 0 = F81F (magenta), word 1 = 7BEF (grey 7/7/7), then FFFF.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_q    <= (pop_total == 0) ? 16'hF81F :
                         (pop_total == 1) ? 16'h7BEF : 16'hFFFF;
            pop_total <= pop_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        fc = (fc + 1) % FRAME;
    endtask

    // Expected pin syncs at frame cycle c (pins lag counters by 2).
    function automatic logic exp_hs(input int c);
        int p = (c - 2 + FRAME) % FRAME;
        return !(((p % HT) >= 10) && ((p % HT) < 12));
    endfunction

    function automatic logic exp_vs(input int c);
        int p = (c - 2 + FRAME) % FRAME;
        return !((p / HT) == 5);
    endfunction

    initial begin
        int errs, rd_cnt, fs_cnt;
        logic [11:0] pat_exp;
`ifdef VGA_TESTPATTERN_EN
        pat_exp = 12'hF0F;
`else
        pat_exp = 12'h000;
`endif
        reset_reset = 1'b1;
        pll_locked  = 1'b0;
        fifo_empty  = 1'b1;
        fifo_used   = 9'd0;
        repeat (3) step();
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_eq("rst_hs", vga_hs, 1);
        check_eq("rst_vs", vga_vs, 1);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_underflow", underflow, 0);

        // Out of reset, no lock: idle for 100 cycles
        reset_reset = 1'b0;
        errs = 0;
        repeat (100) begin
            step();
            if (fifo_rd_en !== 1'b0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || rgb !== 12'h0)
                errs++;
        end
        check_eq("unlocked_idle", errs, 0);

        // Lock with used=3: one full frame in S_FILL, no reads
        fifo_used  = 9'd3;
        pll_locked = 1'b1;
        step();
        fc = 0;
        rd_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (fifo_rd_en) rd_cnt++;
            step();
        end
        check_eq("fill_no_reads", rd_cnt, 0);

        // Second fill frame: pattern pixel, prefill reached mid-frame
        fifo_empty = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (fc == 7) check_eq("fill_pixel_h5", rgb, pat_exp);
            if (fc == 50) fifo_used = 9'd4;
            if (fifo_rd_en) rd_cnt++;
            step();
        end
        check_eq("fill2_no_reads", rd_cnt, 0);
        check_eq("first_rd_en_h0v0", fifo_rd_en, 1);

        // First RUN frame, FIFO never empty
        rd_cnt = 0; fs_cnt = 0; errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (fc == 2)  check_eq("pix0_magenta", rgb, 12'hF0F);
            if (fc == 3)  check_eq("pix1_grey", rgb, 12'h777);
            if (fc == 10) check_eq("hblank_black", rgb, 12'h000);
            if (fc == 2)  check_eq("frame_start_pos", frame_start, 1);
            if (fifo_rd_en) rd_cnt++;
            if (frame_start) fs_cnt++;
            if (vga_hs !== exp_hs(fc) || vga_vs !== exp_vs(fc)) errs++;
            step();
        end
        check_eq("pops_per_frame", rd_cnt, 32);
        check_eq("frame_start_count", fs_cnt, 1);
        check_eq("sync_timing", errs, 0);
        check_eq("underflow_clear", underflow, 0);

        // Starve pixel h=3,v=1 (frame cycle 17)
        repeat (17) step();
        fifo_empty = 1'b1;
        #1;
        check_eq("starved_no_pop", fifo_rd_en, 0);
        step();
        fifo_empty = 1'b0;
        check_eq("underflow_set", underflow, 1);
        check_eq("pre_starve_pixel", rgb, 12'hFFF);
        step();
        check_eq("starved_black", rgb, 12'h000);
        while (fc != 0) step();
        repeat (2 * FRAME) step();
        check_eq("underflow_sticky", underflow, 1);

        // Lose lock mid-line (h=6, v=1)
        repeat (20) step();
        pll_locked = 1'b0;
        step();
        check_eq("unlock_rd_en", fifo_rd_en, 0);
        check_eq("unlock_hs", vga_hs, 1);
        check_eq("unlock_vs", vga_vs, 1);
        check_eq("unlock_rgb", rgb, 0);
        errs = 0;
        repeat (5) begin
            step();
            if (fifo_rd_en !== 1'b0) errs++;
        end
        check_eq("unlock_hold", errs, 0);

        // Relock: one S_FILL frame, then RUN exactly at h=0,v=0
        pll_locked = 1'b1;
        step();
        fc = 0;
        rd_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (fifo_rd_en) rd_cnt++;
            if (frame_start) fs_cnt++;
            step();
        end
        check_eq("relock_fill_no_reads", rd_cnt, 0);
        check_eq("relock_frame_start", fs_cnt, 1);
        check_eq("relock_run_start", fifo_rd_en, 1);

        // Reset mid-frame
        repeat (5) step();
        reset_reset = 1'b1;
        step();
        check_eq("midreset_rd_en", fifo_rd_en, 0);
        check_eq("midreset_underflow", underflow, 0);
        reset_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
